rvfi_imem_model: RTL and testbench
==================================

# rvfi_imem_model

Instruction-fetch memory model for formal and simulation harnesses. It serves the core's fetch requests with response data that agrees with the constrained halfword (`imem_addr` / `imem_data`) checked against retired RVFI instructions, and fills all other halfwords from a free input. It sits between the core's instruction port and the harness top level, directly upstream of the RVFI instruction-memory check. It provides in-order responses with configurable latency, a bounded outstanding queue and valid/ready handshakes on both sides.

## Interface
- `XLEN`, 32, address width (32 or 64).
- `LATENCY`, 1, cycles from fetch acceptance to earliest response (1..4).
- `QDEPTH`, 2, maximum outstanding fetches (power of two, 1..8).

Ports:
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `imem_addr`  in  XLEN  constrained halfword address, bit 0 always 0.
- `imem_data`  in  16  constrained halfword value.
- `free_data`  in  32  unconstrained filler, driven `$anyseq` at top level.
- `fetch_valid`  in  1  core fetch request.
- `fetch_ready`  out  1  model can accept a request.
- `fetch_addr`  in  XLEN  fetch address; bit 0 ignored.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  core accepts the response.
- `resp_addr`  out  XLEN  address of the responded fetch (bit 0 cleared).
- `resp_data`  out  32  instruction word; `[15:0]` is at `addr`, `[31:16]` is at `addr+2`.
- `outstanding`  out  4  number of queued entries.

## Operation
- Accept a fetch when `fetch_valid && fetch_ready`. Push the entry `{a = fetch_addr & ~1, data, age = 1}` at that edge.
- Data is composed at acceptance:
  - Low half = `imem_data` if `a == imem_addr`, else `free_data[15:0]`.
  - High half = `imem_data` if `a+2 == imem_addr` (mod 2^XLEN), else `free_data[31:16]`.
- Both halves may not match at once, because `imem_addr` is a single halfword.
- Queue is an in-order FIFO. Read/write pointers are `clog2(QDEPTH)` bits and wrap modulo QDEPTH. `outstanding` counts 0..QDEPTH.
- Each entry's age increments every cycle and saturates at LATENCY.
- `fetch_ready = resetn && (outstanding < QDEPTH)`. There is no same-cycle bypass: when full, a pop does not free a slot until the next cycle.
- `resp_valid = (outstanding != 0) && (head.age == LATENCY)`. `resp_addr` and `resp_data` show the head entry.
- Pop on `resp_valid && resp_ready`.
- Simultaneous push and pop: `outstanding` is unchanged and both pointers advance.
- Backpressure: while `resp_valid && !resp_ready`, `resp_addr` and `resp_data` hold stable and `resp_valid` stays high.
- `imem_addr` and `imem_data` are sampled only at acceptance. Later changes do not alter queued data. At top level they are `$anyconst`.

## Timing
- Reset (async, `resetn` low): pointers = 0, `outstanding` = 0, all ages = 0.
  - `resp_valid` = 0 and `fetch_ready` = 0 immediately.
  - `resp_addr` = 0, `resp_data` = 0.
- First acceptance is possible on the first rising edge with `resetn` high.
- Latency: a request accepted at edge N gives `resp_valid` high in the cycle following edge N+LATENCY-1. With LATENCY=1, the response is visible in the cycle after acceptance.
- Back-to-back acceptance: one fetch per cycle while not full. The sustained response rate is one per cycle when `resp_ready` = 1 and QDEPTH ≥ LATENCY+1.
- Reset mid-operation: all queued entries are discarded and `resp_valid` drops asynchronously. No discarded entry is ever emitted after reset release.
- Empty and full conditions are derived from `outstanding`, never from pointer equality alone.

## Test plan
- Reset: hold `resetn` low 3 cycles with `fetch_valid` = 1 -> `fetch_ready` = 0, `resp_valid` = 0, `outstanding` = 0 throughout.
- LATENCY=2, `imem_addr` = 0x100, `imem_data` = 0xABCD, `free_data` = 0x12345678; fetch 0x100 at edge N -> `resp_valid` high in the cycle after edge N+1, `resp_data` = 0x1234ABCD, `resp_addr` = 0x100.
- Same setup, fetch 0xFF (bit 0 ignored, a = 0xFE) -> `resp_addr` = 0xFE, `resp_data` = 0xABCD5678.
- QDEPTH=2, `resp_ready` = 0, fetches to 0x0, 0x4, 0x8 on consecutive cycles -> the first two are accepted, `fetch_ready` = 0 on the third, `resp_data`/`resp_addr` for 0x0 are held stable. Raising `resp_ready` then yields 0x0 and 0x4 in order, and 0x8 is accepted one cycle after the first pop.
- Wrap: XLEN=32, `imem_addr` = 0x0, `imem_data` = 0x5555, fetch 0xFFFFFFFE -> `resp_data[31:16]` = 0x5555, `resp_data[15:0]` = `free_data[15:0]`.
- Reset mid-operation: two entries outstanding, `resetn` pulsed low between edges -> `resp_valid` falls immediately, `outstanding` = 0, and the first response after release belongs to a post-reset fetch.

Source files
------------

// File: rtl/rvfi_imem_model.sv
// Instruction-fetch memory model for RVFI harnesses.
// Responses carry imem_data wherever the fetched halfword hits imem_addr.
// All other halfwords come from free_data. In-order FIFO, fixed latency,
// valid/ready handshakes on both the fetch side and the response side.
module rvfi_imem_model #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 1,
    parameter int QDEPTH  = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [XLEN-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    input  logic [31:0]     free_data,
    input  logic            fetch_valid,
    output logic            fetch_ready,
    input  logic [XLEN-1:0] fetch_addr,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_addr,
    output logic [31:0]     resp_data,
    output logic [3:0]      outstanding
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [2:0] LAT = 3'(LATENCY);

    logic [XLEN-1:0] addr_q [QDEPTH];
    logic [31:0]     data_q [QDEPTH];
    logic [2:0]      age_q  [QDEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [3:0]      count;

    logic            push, pop;
    logic [XLEN-1:0] a_lo, a_hi;
    logic [31:0]     push_data;

    // Pointer advance with explicit wrap, so QDEPTH=1 also behaves.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshakes; full/empty come from the occupancy count only.
    always_comb begin
        fetch_ready = resetn && (count < 4'(QDEPTH));
        resp_valid  = (count != 4'd0) && (age_q[rd_ptr] == LAT);
        push        = fetch_valid && fetch_ready;
        pop         = resp_valid && resp_ready;
        resp_addr   = addr_q[rd_ptr];
        resp_data   = data_q[rd_ptr];
        outstanding = count;
    end

    // Compose the response word from the constrained halfword and filler.
    always_comb begin
        a_lo      = fetch_addr & ~XLEN'(1);
        a_hi      = a_lo + XLEN'(2);
        push_data = free_data;
        if (a_lo == imem_addr) push_data[15:0]  = imem_data;
        if (a_hi == imem_addr) push_data[31:16] = imem_data;
    end

    // Queue storage, per-entry aging, pointers and occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            // Ages of free slots also move, but a push always restarts them at 1.
            for (int i = 0; i < QDEPTH; i++)
                if (age_q[i] != LAT) age_q[i] <= age_q[i] + 3'd1;
            if (push) begin
                addr_q[wr_ptr] <= a_lo;
                data_q[wr_ptr] <= push_data;
                age_q[wr_ptr]  <= 3'd1;
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + 4'd1;
            else if (pop && !push) count <= count - 4'd1;
        end
    end

endmodule

// File: tb/tb_rvfi_imem_model.sv
// Directed bench for rvfi_imem_model (XLEN=32, LATENCY=2, QDEPTH=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rvfi_imem_model;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] imem_addr = '0;
    logic [15:0] imem_data = '0;
    logic [31:0] free_data = '0;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [31:0] fetch_addr = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_addr;
    logic [31:0] resp_data;
    logic [3:0]  outstanding;

    int checks = 0;
    int errors = 0;

    rvfi_imem_model #(.XLEN(32), .LATENCY(2), .QDEPTH(2)) dut (
        .clk(clk), .resetn(resetn),
        .imem_addr(imem_addr), .imem_data(imem_data), .free_data(free_data),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_addr(fetch_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_addr(resp_addr), .resp_data(resp_data), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        // Reset held with a pending fetch request.
        fetch_valid = 1'b1;
        fetch_addr  = 32'h40;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_fetch_ready", 64'(fetch_ready), 64'd0);
            chk("rst_resp_valid",  64'(resp_valid),  64'd0);
            chk("rst_outstanding", 64'(outstanding), 64'd0);
        end
        chk("rst_resp_addr", 64'(resp_addr), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        resetn      = 1'b1;
        fetch_valid = 1'b0;
        resp_ready  = 1'b1;
        imem_addr   = 32'h100;
        imem_data   = 16'hABCD;
        free_data   = 32'h12345678;
        tick();

        // Low-half hit, latency 2.
        fetch_valid = 1'b1; fetch_addr = 32'h100;
        chk("t1_fetch_ready", 64'(fetch_ready), 64'd1);
        tick();
        fetch_valid = 1'b0;
        chk("t1_not_yet", 64'(resp_valid), 64'd0);
        chk("t1_outstanding", 64'(outstanding), 64'd1);
        tick();
        chk("t1_resp_valid", 64'(resp_valid), 64'd1);
        chk("t1_resp_addr",  64'(resp_addr),  64'h100);
        chk("t1_resp_data",  64'(resp_data),  64'h1234ABCD);
        tick();
        chk("t1_drained", 64'(outstanding), 64'd0);
        chk("t1_valid_low", 64'(resp_valid), 64'd0);

        // Odd address: bit 0 dropped, high-half hit.
        fetch_valid = 1'b1; fetch_addr = 32'hFF;
        tick();
        fetch_valid = 1'b0;
        tick();
        chk("t2_resp_valid", 64'(resp_valid), 64'd1);
        chk("t2_resp_addr",  64'(resp_addr),  64'hFE);
        chk("t2_resp_data",  64'(resp_data),  64'hABCD5678);
        tick();

        // Fill to QDEPTH with backpressure.
        resp_ready = 1'b0;
        fetch_valid = 1'b1; fetch_addr = 32'h0;
        tick();
        fetch_addr = 32'h4;
        chk("t3_ready_2nd", 64'(fetch_ready), 64'd1);
        tick();
        fetch_addr = 32'h8;
        chk("t3_ready_full", 64'(fetch_ready), 64'd0);
        chk("t3_out_full",   64'(outstanding), 64'd2);
        chk("t3_head_valid", 64'(resp_valid),  64'd1);
        chk("t3_head_addr",  64'(resp_addr),   64'h0);
        free_data = 32'hDEADBEEF;
        tick();
        chk("t3_hold_valid", 64'(resp_valid), 64'd1);
        chk("t3_hold_addr",  64'(resp_addr),  64'h0);
        chk("t3_hold_data",  64'(resp_data),  64'h12345678);
        chk("t3_still_full", 64'(fetch_ready), 64'd0);
        resp_ready = 1'b1;
        tick();
        chk("t3_2nd_addr",  64'(resp_addr),   64'h4);
        chk("t3_2nd_valid", 64'(resp_valid),  64'd1);
        chk("t3_2nd_data",  64'(resp_data),   64'h12345678);
        chk("t3_ready_free", 64'(fetch_ready), 64'd1);
        chk("t3_out_one",   64'(outstanding), 64'd1);
        tick();
        fetch_valid = 1'b0;
        chk("t3_pushpop_out", 64'(outstanding), 64'd1);
        chk("t3_8_young",     64'(resp_valid),  64'd0);
        tick();
        chk("t3_3rd_valid", 64'(resp_valid), 64'd1);
        chk("t3_3rd_addr",  64'(resp_addr),  64'h8);
        chk("t3_3rd_data",  64'(resp_data),  64'hDEADBEEF);
        tick();
        chk("t3_empty", 64'(outstanding), 64'd0);

        // Address wrap; constrained inputs changing after acceptance.
        imem_addr = 32'h0; imem_data = 16'h5555;
        fetch_valid = 1'b1; fetch_addr = 32'hFFFFFFFE;
        tick();
        fetch_valid = 1'b0;
        imem_data = 16'h0000;
        free_data = 32'h0;
        tick();
        chk("t4_wrap_valid", 64'(resp_valid), 64'd1);
        chk("t4_wrap_addr",  64'(resp_addr),  64'hFFFFFFFE);
        chk("t4_wrap_data",  64'(resp_data),  64'h5555BEEF);
        tick();

        // Reset pulse with two entries queued.
        resp_ready = 1'b0;
        free_data = 32'h11112222;
        fetch_valid = 1'b1; fetch_addr = 32'h10;
        tick();
        fetch_addr = 32'h14;
        tick();
        fetch_valid = 1'b0;
        chk("t5_two_queued", 64'(outstanding), 64'd2);
        chk("t5_pre_valid",  64'(resp_valid),  64'd1);
        #2 resetn = 1'b0;
        #1;
        chk("t5_async_valid", 64'(resp_valid),  64'd0);
        chk("t5_async_out",   64'(outstanding), 64'd0);
        chk("t5_async_ready", 64'(fetch_ready), 64'd0);
        #1 resetn = 1'b1;
        resp_ready = 1'b1;
        tick();
        chk("t5_no_ghost_a", 64'(resp_valid), 64'd0);
        free_data = 32'hCAFEF00D;
        fetch_valid = 1'b1; fetch_addr = 32'h20;
        tick();
        fetch_valid = 1'b0;
        chk("t5_no_ghost_b", 64'(resp_valid), 64'd0);
        tick();
        chk("t5_post_valid", 64'(resp_valid), 64'd1);
        chk("t5_post_addr",  64'(resp_addr),  64'h20);
        chk("t5_post_data",  64'(resp_data),  64'hCAFEF00D);
        tick();
        chk("t5_post_empty", 64'(outstanding), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
